// File: rtl/mine_index_scheduler.sv
// rtl/mine_index_scheduler.sv - neighbour-count char code sequencer for the mine board
// Purpose: on a refresh request, walks every board field in row-major order, reads the
//          field and its 8 neighbours from the mine map (1-cycle read latency) and writes
//          one char code per field: 0-8 neighbour mine count, 9 when the field is a mine.
// Ports:   clk, rst_n (async active-low), vblnk, button_num (board side, clamped),
//          start_refresh, mine_rd_en/x/y + mine_rd_data (mine-map read port),
//          wr_en/x/y/data (char-memory write port), busy, done (one-cycle pulse).
// Build option: REFRESH_ANYTIME_EN - when defined vblnk is ignored and field starts are
//               never held off; when undefined a field may only start during vblnk.
module mine_index_scheduler #(
    parameter int MAX_BUTTONS = 16,
    parameter int CODE_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vblnk,
    input  logic [4:0]        button_num,
    input  logic              start_refresh,
    output logic              mine_rd_en,
    output logic [4:0]        mine_rd_x,
    output logic [4:0]        mine_rd_y,
    input  logic              mine_rd_data,
    output logic              wr_en,
    output logic [4:0]        wr_x,
    output logic [4:0]        wr_y,
    output logic [CODE_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, WAIT_VB, READ, DRAIN, WRITE, NEXT} state_t;

    localparam logic [4:0] MAX_N = 5'(MAX_BUTTONS);

    state_t     state_q, state_d;
    logic [4:0] n_q, n_d, x_q, x_d, y_q, y_d;
    logic [3:0] k_q, k_d, kd_q, kd_d, cnt_q, cnt_d;
    logic       mine_q, mine_d, en_q, en_d, pend_q, pend_d, zdone_q, zdone_d;
    logic [4:0] n_req, off_x, off_y;
    logic [1:0] k_row, k_col;
    logic       in_bounds, vb_ok, last_x, last_y;

`ifdef REFRESH_ANYTIME_EN
    assign vb_ok = 1'b1;
`else
    assign vb_ok = vblnk;
`endif

    // Offset k walks the 3x3 window row by row: (dx,dy) = (k%3-1, k/3-1).
    always_comb begin
        k_row = (k_q >= 4'd6) ? 2'd2 : ((k_q >= 4'd3) ? 2'd1 : 2'd0);
        k_col = 2'(k_q - 4'(k_row) * 4'd3);
    end

    // Negative offsets wrap to 31, which is always >= n, so one unsigned compare
    // covers both board edges.
    assign off_x     = x_q + 5'(k_col) - 5'd1;
    assign off_y     = y_q + 5'(k_row) - 5'd1;
    assign in_bounds = (off_x < n_q) && (off_y < n_q);
    assign n_req     = (button_num > MAX_N) ? MAX_N : button_num;
    assign last_x    = (x_q == n_q - 5'd1);
    assign last_y    = (y_q == n_q - 5'd1);
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        x_d        = x_q;
        y_d        = y_q;
        k_d        = k_q;
        kd_d       = k_q;
        en_d       = 1'b0;
        cnt_d      = cnt_q;
        mine_d     = mine_q;
        zdone_d    = 1'b0;
        pend_d     = pend_q | (start_refresh && (state_q != IDLE));
        mine_rd_en = 1'b0;
        mine_rd_x  = 5'd0;
        mine_rd_y  = 5'd0;
        wr_en      = 1'b0;
        wr_x       = 5'd0;
        wr_y       = 5'd0;
        wr_data    = '0;
        done       = zdone_q;

        // Read data belongs to the offset issued one cycle earlier.
        if (en_q && mine_rd_data) begin
            if (kd_q == 4'd4) mine_d = 1'b1;
            else              cnt_d  = cnt_q + 4'd1;
        end

        case (state_q)
            IDLE: begin
                if (start_refresh || pend_q) begin
                    n_d    = n_req;
                    pend_d = 1'b0;
                    x_d    = 5'd0;
                    y_d    = 5'd0;
                    if (n_req == 5'd0) zdone_d = 1'b1;
                    else               state_d = WAIT_VB;
                end
            end
            WAIT_VB: begin
                if (vb_ok) begin
                    state_d = READ;
                    k_d     = 4'd0;
                end
            end
            READ: begin
                mine_rd_en = in_bounds;
                mine_rd_x  = off_x;
                mine_rd_y  = off_y;
                en_d       = in_bounds;
                if (k_q == 4'd8) begin
                    state_d = DRAIN;
                    k_d     = 4'd0;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            DRAIN: state_d = WRITE;
            WRITE: begin
                wr_en   = 1'b1;
                wr_x    = x_q;
                wr_y    = y_q;
                wr_data = mine_q ? CODE_W'(9) : CODE_W'(cnt_q);
                cnt_d   = 4'd0;
                mine_d  = 1'b0;
                state_d = NEXT;
            end
            NEXT: begin
                // NEXT doubles as the vblnk gate of the following field.
                k_d = 4'd0;
                if (last_x && last_y) begin
                    done    = 1'b1;
                    x_d     = 5'd0;
                    y_d     = 5'd0;
                    state_d = IDLE;
                end else begin
                    if (last_x) begin
                        x_d = 5'd0;
                        y_d = y_q + 5'd1;
                    end else begin
                        x_d = x_q + 5'd1;
                    end
                    state_d = vb_ok ? READ : WAIT_VB;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_q     <= 5'd0;
            x_q     <= 5'd0;
            y_q     <= 5'd0;
            k_q     <= 4'd0;
            kd_q    <= 4'd0;
            en_q    <= 1'b0;
            cnt_q   <= 4'd0;
            mine_q  <= 1'b0;
            pend_q  <= 1'b0;
            zdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            x_q     <= x_d;
            y_q     <= y_d;
            k_q     <= k_d;
            kd_q    <= kd_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
            mine_q  <= mine_d;
            pend_q  <= pend_d;
            zdone_q <= zdone_d;
        end
    end
endmodule

// File: tb/tb_mine_index_scheduler.sv
// tb/tb_mine_index_scheduler.sv - randomized self-checking bench for mine_index_scheduler
module tb_mine_index_scheduler;
    localparam int CODE_W = 4;
    localparam int HN     = 32768;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              vblnk = 1'b0;
    logic [4:0]        button_num = 5'd0;
    logic              start_refresh = 1'b0;
    logic              mine_rd_data = 1'b0;
    logic              mine_rd_en, wr_en, busy, done;
    logic [4:0]        mine_rd_x, mine_rd_y, wr_x, wr_y;
    logic [CODE_W-1:0] wr_data;

    int checks = 0;
    int fails  = 0;

    bit map_mem [0:31][0:31];
    logic [13:0] wq[$];
    logic [13:0] eq[$];
    int exp_reads, rd_cnt, done_cnt, field_err, overlap_err;
    int cyc = 0;
    int h, c;
    bit         vb_h [HN];
    bit         en_h [HN];
    logic [4:0] x_h  [HN];
    logic [4:0] y_h  [HN];
    logic       pend_en = 1'b0;
    logic [4:0] pend_x = 5'd0, pend_y = 5'd0;

    always #5 clk = ~clk;

    mine_index_scheduler #(.MAX_BUTTONS(16), .CODE_W(CODE_W)) dut (
        .clk(clk), .rst_n(rst_n), .vblnk(vblnk), .button_num(button_num),
        .start_refresh(start_refresh), .mine_rd_en(mine_rd_en), .mine_rd_x(mine_rd_x),
        .mine_rd_y(mine_rd_y), .mine_rd_data(mine_rd_data), .wr_en(wr_en), .wr_x(wr_x),
        .wr_y(wr_y), .wr_data(wr_data), .busy(busy), .done(done)
    );

    // Mine map with one cycle of read latency; garbage is driven when no read is pending.
    always @(negedge clk) begin
        pend_en = mine_rd_en;
        pend_x  = mine_rd_x;
        pend_y  = mine_rd_y;
    end
    always @(posedge clk) begin
        #1;
        mine_rd_data = pend_en ? map_mem[pend_y][pend_x] : 1'($urandom);
    end

    // Activity recorder: writes, reads, done pulses and per-field timing shape.
    always @(negedge clk) begin
        cyc++;
        h = cyc % HN;
        vb_h[h] = vblnk;
        en_h[h] = mine_rd_en;
        x_h[h]  = mine_rd_x;
        y_h[h]  = mine_rd_y;
        if (mine_rd_en) rd_cnt++;
        if (done) done_cnt++;
        if (mine_rd_en && wr_en) overlap_err++;
        if (wr_en) begin
            wq.push_back({wr_x, wr_y, wr_data});
            c = (cyc - 6) % HN;
            if (!(en_h[c] && x_h[c] == wr_x && y_h[c] == wr_y)) field_err++;
`ifndef REFRESH_ANYTIME_EN
            if (!vb_h[(cyc - 11) % HN]) field_err++;
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wq.delete();
        eq.delete();
        exp_reads = 0;
        rd_cnt = 0;
        done_cnt = 0;
        field_err = 0;
        overlap_err = 0;
    endtask

    task automatic rand_map(input int pct);
        foreach (map_mem[i, j]) map_mem[i][j] = ($urandom_range(99) < pct);
    endtask

    task automatic clr_map();
        foreach (map_mem[i, j]) map_mem[i][j] = 1'b0;
    endtask

    // Reference: the char code of a field is 9 for a mine, otherwise the number of
    // mines among its in-board neighbours; fields are produced row-major.
    task automatic build_expected(input int nb);
        int n, cnt, xx, yy, code;
        n = (nb > 16) ? 16 : nb;
        for (int y = 0; y < n; y++) begin
            for (int x = 0; x < n; x++) begin
                cnt = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        xx = x + dx;
                        yy = y + dy;
                        if (xx >= 0 && xx < n && yy >= 0 && yy < n) begin
                            exp_reads++;
                            if ((dx != 0 || dy != 0) && map_mem[yy][xx]) cnt++;
                        end
                    end
                end
                code = map_mem[y][x] ? 9 : cnt;
                eq.push_back({5'(x), 5'(y), 4'(code)});
            end
        end
    endtask

    function automatic int diff_count();
        int d = 0;
        if (wq.size() != eq.size()) return -1;
        foreach (eq[i]) if (wq[i] !== eq[i]) d++;
        return d;
    endfunction

    task automatic run_refresh(input int nb, input int budget, output int lat);
        int t = 0;
        button_num = 5'(nb);
        start_refresh = 1'b1;
        lat = -1;
        while (lat < 0 && t < budget) begin
            step();
            t++;
            start_refresh = 1'b0;
            if (done) lat = t;
        end
        start_refresh = 1'b0;
        step();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({mine_rd_en, mine_rd_x, mine_rd_y, wr_en, wr_x, wr_y, wr_data, busy, done} !== 32'd0) begin
            fails++;
            $display("FAIL reset_outputs got %h required 0",
                     {mine_rd_en, mine_rd_x, mine_rd_y, wr_en, wr_x, wr_y, wr_data, busy, done});
        end
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if ({busy, done, wr_en, mine_rd_en} !== 4'd0) begin
            fails++;
            $display("FAIL idle_after_reset got %b required 0000", {busy, done, wr_en, mine_rd_en});
        end
    endtask

    task automatic test_2x2();
        int t = 0, lat = -1, busy_bad = 0, d;
        clr_map();
        map_mem[0][0] = 1'b1;
        vblnk = 1'b1;
        clear_mon();
        build_expected(2);
        button_num = 5'd2;
        start_refresh = 1'b1;
        while (lat < 0 && t < 200) begin
            step();
            t++;
            start_refresh = 1'b0;
            if (busy !== 1'b1) busy_bad++;
            if (done) lat = t;
        end
        step();
        d = diff_count();
        checks++;
        if (lat !== 49) begin fails++; $display("FAIL lat_2x2 got %0d required 49", lat); end
        checks++;
        if (busy_bad !== 0) begin fails++; $display("FAIL busy_2x2 low_cycles=%0d required 0", busy_bad); end
        checks++;
        if (d !== 0) begin fails++; $display("FAIL writes_2x2 mismatches=%0d required 0", d); end
        checks++;
        if (eq.size() == 4 && wq.size() == 4 && wq[0] !== {5'd0, 5'd0, 4'd9}) begin
            fails++;
            $display("FAIL first_write_2x2 got %h required %h", wq[0], {5'd0, 5'd0, 4'd9});
        end
        checks++;
        if (rd_cnt !== exp_reads) begin fails++; $display("FAIL reads_2x2 got %0d required %0d", rd_cnt, exp_reads); end
        checks++;
        if (overlap_err !== 0 || field_err !== 0) begin
            fails++;
            $display("FAIL shape_2x2 overlap=%0d field=%0d required 0 0", overlap_err, field_err);
        end
    endtask

    task automatic test_3x3();
        int lat, d;
        vblnk = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) foreach (map_mem[i, j]) map_mem[i][j] = 1'b1;
            else begin clr_map(); map_mem[1][1] = 1'b1; end
            clear_mon();
            build_expected(3);
            run_refresh(3, 300, lat);
            d = diff_count();
            checks++;
            if (lat !== 109) begin fails++; $display("FAIL lat_3x3_%0d got %0d required 109", pass, lat); end
            checks++;
            if (d !== 0) begin fails++; $display("FAIL writes_3x3_%0d mismatches=%0d required 0", pass, d); end
            checks++;
            if (rd_cnt !== exp_reads) begin
                fails++;
                $display("FAIL reads_3x3_%0d got %0d required %0d", pass, rd_cnt, exp_reads);
            end
        end
    endtask

    task automatic test_vblnk_gating();
        int t = 0, lat = -1, d;
        rand_map(35);
        clear_mon();
        build_expected(4);
        button_num = 5'd4;
        vblnk = 1'b1;
        start_refresh = 1'b1;
        while (lat < 0 && t < 3000) begin
            step();
            t++;
            start_refresh = 1'b0;
            vblnk = ((t % 50) < 20);
            if (done) lat = t;
        end
        step();
        vblnk = 1'b1;
        d = diff_count();
        checks++;
        if (lat < 0) begin fails++; $display("FAIL done_vblnk got timeout required done"); end
        checks++;
        if (d !== 0) begin fails++; $display("FAIL writes_vblnk mismatches=%0d required 0", d); end
        checks++;
        if (field_err !== 0 || overlap_err !== 0) begin
            fails++;
            $display("FAIL gating_vblnk field=%0d overlap=%0d required 0 0", field_err, overlap_err);
        end
    endtask

    task automatic test_pending();
        int t = 0, d1 = -1, d2 = -1, d;
        rand_map(40);
        vblnk = 1'b1;
        clear_mon();
        build_expected(2);
        build_expected(2);
        button_num = 5'd2;
        start_refresh = 1'b1;
        while (d2 < 0 && t < 400) begin
            step();
            t++;
            start_refresh = (t == 5 || t == 10);
            if (done) begin
                if (d1 < 0) d1 = t;
                else        d2 = t;
            end
        end
        start_refresh = 1'b0;
        repeat (80) step();
        d = diff_count();
        checks++;
        if (d1 !== 49 || d2 !== 99) begin
            fails++;
            $display("FAIL pending_done_times got %0d,%0d required 49,99", d1, d2);
        end
        checks++;
        if (done_cnt !== 2) begin fails++; $display("FAIL pending_done_count got %0d required 2", done_cnt); end
        checks++;
        if (d !== 0) begin fails++; $display("FAIL pending_writes mismatches=%0d required 0", d); end
    endtask

    task automatic test_reset_mid();
        int lat, d;
        rand_map(40);
        vblnk = 1'b1;
        clear_mon();
        button_num = 5'd3;
        start_refresh = 1'b1;
        step();
        start_refresh = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mine_rd_en, mine_rd_x, mine_rd_y, wr_en, wr_x, wr_y, wr_data, busy, done} !== 32'd0) begin
            fails++;
            $display("FAIL reset_mid_outputs got %h required 0",
                     {mine_rd_en, mine_rd_x, mine_rd_y, wr_en, wr_x, wr_y, wr_data, busy, done});
        end
        step();
        rst_n = 1'b1;
        repeat (30) step();
        checks++;
        if (wq.size() !== 0 || done_cnt !== 0) begin
            fails++;
            $display("FAIL reset_mid_quiet writes=%0d done=%0d required 0 0", wq.size(), done_cnt);
        end
        clear_mon();
        build_expected(3);
        run_refresh(3, 300, lat);
        d = diff_count();
        checks++;
        if (lat !== 109 || d !== 0) begin
            fails++;
            $display("FAIL reset_mid_rerun lat=%0d mismatches=%0d required 109 0", lat, d);
        end
    endtask

    task automatic test_clamp();
        int lat, d;
        vblnk = 1'b1;
        clear_mon();
        run_refresh(0, 20, lat);
        repeat (10) step();
        checks++;
        if (lat !== 1) begin fails++; $display("FAIL zero_lat got %0d required 1", lat); end
        checks++;
        if (wq.size() !== 0 || rd_cnt !== 0) begin
            fails++;
            $display("FAIL zero_activity writes=%0d reads=%0d required 0 0", wq.size(), rd_cnt);
        end
        rand_map(20);
        clear_mon();
        build_expected(31);
        run_refresh(31, 4000, lat);
        d = diff_count();
        checks++;
        if (lat !== 3073) begin fails++; $display("FAIL clamp_lat got %0d required 3073", lat); end
        checks++;
        if (d !== 0) begin fails++; $display("FAIL clamp_writes mismatches=%0d required 0", d); end
        checks++;
        if (wq.size() == 0 || wq[wq.size()-1][13:4] !== {5'd15, 5'd15}) begin
            fails++;
            $display("FAIL clamp_last_xy got %h required %h",
                     (wq.size() == 0) ? 10'h0 : wq[wq.size()-1][13:4], {5'd15, 5'd15});
        end
    endtask

    task automatic test_random();
        int lat, d, n;
        vblnk = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n = $urandom_range(1, 6);
            rand_map($urandom_range(10, 70));
            clear_mon();
            build_expected(n);
            run_refresh(n, 1000, lat);
            d = diff_count();
            checks++;
            if (lat !== 12 * n * n + 1) begin
                fails++;
                $display("FAIL rand_lat_%0d n=%0d got %0d required %0d", i, n, lat, 12 * n * n + 1);
            end
            checks++;
            if (d !== 0 || rd_cnt !== exp_reads) begin
                fails++;
                $display("FAIL rand_data_%0d n=%0d mismatches=%0d reads=%0d required 0 %0d",
                         i, n, d, rd_cnt, exp_reads);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_2x2();
        test_3x3();
        test_vblnk_gating();
        test_pending();
        test_reset_mid();
        test_clamp();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
